// File: rtl/priority_encoder_capture_pkg.sv
// Shared widths, FSM state encoding and the priority-encode helper for the
// request capture block.
package priority_encoder_capture_pkg;

    localparam int REQ_W = 4;  // number of request lines
    localparam int IDX_W = 2;  // width of an encoded request index

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Index of the highest set bit of req; 0 when req is empty (callers
    // only use the result when req is non-zero).
    function automatic logic [IDX_W-1:0] priority_encode(input logic [REQ_W-1:0] req);
        logic [IDX_W-1:0] idx;
        idx = '0;
        // Ascending scan: a later (higher) set bit overwrites a lower one.
        for (int k = 0; k < REQ_W; k++) begin
            if (req[k]) idx = IDX_W'(k);
        end
        return idx;
    endfunction

endpackage : priority_encoder_capture_pkg

// File: rtl/priority_encoder_capture_sync_edge_detect.sv
// Synchronizer plus rising-edge detector for one asynchronous request line.
// After reset the edge output stays masked until the synchronizer and the
// history flop hold real samples, so a line already high at reset release
// never looks like a new request.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_async,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [SYNC_STAGES:0]   arm_q,  arm_d;

    // Next-state: shift the synchronizer, remember the last synchronized
    // value, and fill the arming shift register with ones after reset.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path (here
        // unconditionally) so no latch is inferred.
        sync_d = {sync_q[SYNC_STAGES-2:0], in_async};
        hist_d = sync_q[SYNC_STAGES-1];
        arm_d  = {arm_q[SYNC_STAGES-1:0], 1'b1};
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            arm_q  <= '0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            arm_q  <= arm_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q & arm_q[SYNC_STAGES];

endmodule : sync_edge_detect

// File: rtl/priority_encoder_capture.sv
// Captures rising edges on four asynchronous request lines into a pending
// mask and presents them one at a time, highest index first, through a
// valid/ready handshake. A repeated edge on a still-pending line is merged
// and flagged with a one-cycle overrun pulse.
module priority_encoder_capture
    import priority_encoder_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REQ_W-1:0] in,
    output logic [IDX_W-1:0] out,
    output logic             valid,
    input  logic             ready,
    output logic             overrun,
    output logic [REQ_W-1:0] pending
);

    logic [REQ_W-1:0] rise;
    logic [IDX_W-1:0] next_idx;

    state_e           state_q,   state_d;
    logic [IDX_W-1:0] out_q,     out_d;
    logic             valid_q,   valid_d;
    logic             overrun_q, overrun_d;
    logic [REQ_W-1:0] pending_q, pending_d;
    logic [REQ_W-1:0] clear_mask;
    logic             load;

    // One synchronizer/edge detector per request line.
    for (genvar k = 0; k < REQ_W; k++) begin : g_sync
        sync_edge_detect #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk     (clk),
            .rst     (rst),
            .in_async(in[k]),
            .rise    (rise[k])
        );
    end

    // Priority encode of the registered pending mask, kept apart from the FSM.
    always_comb begin
        next_idx = priority_encode(pending_q);
    end

    // FSM next-state, output load and pending-mask update.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        valid_d = valid_q;
        load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pending_q != '0) load = 1'b1;
            end
            HOLD: begin
                if (ready) begin
                    if (pending_q != '0) begin
                        load = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            out_d   = next_idx;
            valid_d = 1'b1;
            state_d = HOLD;
        end

        clear_mask = load ? (REQ_W'(1) << next_idx) : '0;
        // A rise on the bit being cleared re-arms it rather than merging.
        pending_d  = (pending_q & ~clear_mask) | rise;
        overrun_d  = |(rise & pending_q & ~clear_mask);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            out_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            pending_q <= pending_d;
        end
    end

    assign out     = out_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;
    assign pending = pending_q;

endmodule : priority_encoder_capture
